// File: rtl/calc_disp_pkg.sv
// calc_disp_pkg
//   Shared definitions for the calculator result display:
//   converter FSM states, widths, segment codes and the digit-to-segment table.
//   Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package calc_disp_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int BCD_DIGITS = 3;
    localparam int RES_W      = 9;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam logic [6:0] SEG_TABLE [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    // Non-decimal nibbles cannot occur from the converter; show them blank.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return (d > 4'd9) ? SEG_BLANK : SEG_TABLE[d];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble converter: 9-bit binary to three BCD digits.
//   IDLE -> SHIFT (9 cycles) -> DONE (commit) -> IDLE.
//   Optional macro RESULT_SIGNED_EN: value is two's complement, its magnitude is
//   converted and a sign bit is committed together with the digits.
// Ports
//   clk    in   clock
//   reset  in   synchronous active-high reset
//   start  in   begin a conversion of value (only acted on in IDLE)
//   value  in   9-bit input value
//   busy   out  high during SHIFT and DONE
//   bcd    out  committed {hundreds,tens,ones}
//   sign   out  committed sign (RESULT_SIGNED_EN builds only)
import calc_disp_pkg::*;

module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  value,
`ifdef RESULT_SIGNED_EN
    output logic        sign,
`endif
    output logic        busy,
    output logic [11:0] bcd
);

    state_t      state_q;
    logic [8:0]  sr_q;
    logic [11:0] acc_q;
    logic [3:0]  cnt_q;
    logic [11:0] bcd_q;
    logic        busy_q;
    logic [20:0] shift_d;
    logic [8:0]  mag_d;

    // Add 3 to every nibble >= 5 so the following left shift carries correctly.
    function automatic logic [11:0] dabble_adj(input logic [11:0] a);
        logic [11:0] r;
        r = a;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

`ifdef RESULT_SIGNED_EN
    logic sign_acc_q;
    logic sign_q;
    // -256 wraps to 9'h100, which is the correct magnitude 256.
    assign mag_d = value[8] ? (~value + 9'd1) : value;
    assign sign  = sign_q;
`else
    assign mag_d = value;
`endif

    assign shift_d = {dabble_adj(acc_q), sr_q} << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            bcd_q   <= 12'h000;
            cnt_q   <= 4'd0;
`ifdef RESULT_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q    <= mag_d;
                        acc_q   <= 12'h000;
                        cnt_q   <= 4'd0;
`ifdef RESULT_SIGNED_EN
                        sign_acc_q <= value[8];
`endif
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q <= shift_d[20:9];
                    sr_q  <= shift_d[8:0];
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(RES_W - 1)) state_q <= DONE;
                end
                DONE: begin
                    // All digits (and sign) change on the same edge.
                    bcd_q   <= acc_q;
`ifdef RESULT_SIGNED_EN
                    sign_q  <= sign_acc_q;
`endif
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/result_display.sv
// result_display
//   Drives a 4-digit common-anode 7-segment display from the calculator's
//   9-bit result. A bin2bcd_seq instance converts whenever the result changes
//   (and once after reset); a free-running scanner lights one digit at a time.
//   Optional macro RESULT_SIGNED_EN: signed result, digit 3 shows a minus sign.
// Parameters
//   SCAN_DIV       cycles each digit stays lit (>= 2)
//   BLANK_LEADING  1 = blank leading zeros in hundreds/tens
// Ports
//   clk, reset  clock, synchronous active-high reset
//   result      binary value to display
//   seg         cathodes, active-low {g,f,e,d,c,b,a}
//   dp          decimal point, active-low, always off
//   an          anodes, active-low one-hot, an[0] = rightmost digit
//   busy        conversion in progress
//   bcd         committed digits {hundreds,tens,ones}
import calc_disp_pkg::*;

module result_display #(
    parameter int SCAN_DIV      = 100_000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  result,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        busy,
    output logic [11:0] bcd
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic              pending_q;
    logic [8:0]        last_q;
    logic              start_d;
    logic [SCAN_W-1:0] scan_q;
    logic [1:0]        idx_q;
    logic [3:0]        an_q;
    logic [3:0]        an_d;
    logic [6:0]        seg_q;
    logic [6:0]        seg_d;
    logic              wrap_d;
    logic              sign_w;

    // busy is low exactly while the converter sits in IDLE, so a start here
    // is only ever issued when the converter will accept it.
    assign start_d = ~busy && (pending_q || (result != last_q));

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (start_d),
        .value (result),
`ifdef RESULT_SIGNED_EN
        .sign  (sign_w),
`endif
        .busy  (busy),
        .bcd   (bcd)
    );

`ifndef RESULT_SIGNED_EN
    assign sign_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= 1'b1;
            last_q    <= 9'd0;
        end else if (start_d) begin
            pending_q <= 1'b0;
            last_q    <= result;
        end
    end

    assign wrap_d = (scan_q == SCAN_W'(SCAN_DIV - 1));
    assign an_d   = ~(4'b0001 << idx_q);

    always_comb begin
        seg_d = SEG_BLANK;
        case (idx_q)
            2'd0: seg_d = seg_of(bcd[3:0]);
            2'd1: seg_d = (BLANK_LEADING != 0 && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0)
                          ? SEG_BLANK : seg_of(bcd[7:4]);
            2'd2: seg_d = (BLANK_LEADING != 0 && bcd[11:8] == 4'd0)
                          ? SEG_BLANK : seg_of(bcd[11:8]);
            default: seg_d = sign_w ? SEG_MINUS : SEG_BLANK;
        endcase
    end

    // an and seg are registered together so a digit never shows its neighbour's pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_q <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'hF;
            seg_q  <= SEG_BLANK;
        end else begin
            scan_q <= wrap_d ? '0 : scan_q + 1'b1;
            if (wrap_d) idx_q <= idx_q + 2'd1;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_result_display.sv
// Testbench for result_display (SCAN_DIV=4). A second instance with
// BLANK_LEADING=0 shares the inputs for the blanking comparison.
module tb_result_display;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  result;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;
    logic [3:0]  an, an_nb;
    logic        busy, busy_nb;
    logic [11:0] bcd, bcd_nb;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    result_display #(.SCAN_DIV(4), .BLANK_LEADING(1)) dut (
        .clk(clk), .reset(reset), .result(result),
        .seg(seg), .dp(dp), .an(an), .busy(busy), .bcd(bcd)
    );

    result_display #(.SCAN_DIV(4), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .reset(reset), .result(result),
        .seg(seg_nb), .dp(dp_nb), .an(an_nb), .busy(busy_nb), .bcd(bcd_nb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every commit (busy falling outside reset) pops one expected bcd.
    initial begin
        int   run;
        logic r;
        logic bprev;
        run = 0;
        bprev = 1'b0;
        forever begin
            @(posedge clk);
            r = reset;
            #1;
            if (r === 1'b1) begin
                run = 0;
            end else begin
                if (busy === 1'b1) run++;
                if (bprev === 1'b1 && busy === 1'b0) begin
                    chk("busy_len", run, 10);
                    run = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_commit: got bcd %h with empty queue", bcd);
                    end else begin
                        chk("bcd_commit", bcd, exp_q.pop_front());
                    end
                end
            end
            bprev = busy;
        end
    end

    task automatic wait_drain(input int n);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < n) begin
            @(posedge clk); #2;
            i++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic wait_an(input logic [3:0] pat);
        int i;
        i = 0;
        do begin
            @(posedge clk); #2;
            i++;
        end while (an !== pat && i < 64);
        chk("an_sync", an, pat);
    endtask

    task automatic wait_busy();
        int i;
        i = 0;
        do begin
            @(posedge clk); #2;
            i++;
        end while (busy !== 1'b1 && i < 20);
        chk("busy_rise", busy, 1'b1);
    endtask

    initial begin
        int e;
        logic [3:0] p;

        // 1: reset state and post-reset conversion of 0
        reset  = 1'b1;
        result = 9'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bcd", bcd, 12'h000);
        chk("rst_dp", dp, 1'b1);
        exp_q.push_back(12'h000);
        @(negedge clk) reset = 1'b0;
        wait_drain(40);
        wait_an(4'b1110);
        chk("zero_d0", seg, 7'b1000000);

        // 2: 255, latency and all digits lit
        @(negedge clk);
        result = 9'd255;
        exp_q.push_back(12'h255);
        e = 0;
        do begin
            @(posedge clk); #2;
            e++;
        end while (bcd !== 12'h255 && e < 40);
        chk("lat255", e, 11);
        wait_an(4'b1011); chk("d2_255", seg, 7'b0100100);
        wait_an(4'b1101); chk("d1_255", seg, 7'b0010010);
        wait_an(4'b1110); chk("d0_255", seg, 7'b0010010);
        wait_an(4'b0111); chk("d3_255", seg, 7'h7F);

        // 3: scan sequence, 4 cycles per digit then wrap
        wait_an(4'b1110);
        for (int k = 0; k < 16; k++) begin
            p = ~(4'b0001 << (k / 4));
            chk("scan_an", an, p);
            if (k >= 12) chk("scan_d3", seg, 7'h7F);
            @(posedge clk); #2;
        end
        chk("scan_wrap", an, 4'b1110);

        // 4: leading-zero blanking on/off
        @(negedge clk);
        result = 9'd7;
        exp_q.push_back(12'h007);
        wait_drain(40);
        wait_an(4'b1011);
        chk("bl_d2", seg, 7'h7F);
        chk("nb_d2", seg_nb, 7'b1000000);
        wait_an(4'b1101);
        chk("bl_d1", seg, 7'h7F);
        chk("nb_d1", seg_nb, 7'b1000000);
        wait_an(4'b1110);
        chk("bl_d0", seg, 7'b1111000);
        chk("nb_d0", seg_nb, 7'b1111000);

        // 5a: change during the 3rd SHIFT cycle
        @(negedge clk);
        result = 9'd100;
        exp_q.push_back(12'h100);
        wait_busy();
        repeat (2) @(posedge clk);
        @(negedge clk);
        result = 9'd200;
        exp_q.push_back(12'h200);
        e = 0;
        do begin
            @(posedge clk); #2;
            e++;
        end while (bcd !== 12'h200 && e < 40);
        chk("lat200_le22", (e <= 22), 1'b1);
        wait_drain(10);

        // 5b: reset during the 5th SHIFT cycle, then reconversion
        @(negedge clk);
        result = 9'd37;
        exp_q.push_back(12'h037);
        wait_busy();
        repeat (4) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #2;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_bcd", bcd, 12'h000);
        chk("midrst_an", an, 4'hF);
        @(negedge clk) reset = 1'b0;
        wait_drain(40);
        chk("after_rst_bcd", bcd, 12'h037);

        // 6: all-ones result
        @(negedge clk);
        result = 9'h1FF;
`ifdef RESULT_SIGNED_EN
        exp_q.push_back(12'h001);
`else
        exp_q.push_back(12'h511);
`endif
        wait_drain(40);
        wait_an(4'b0111);
`ifdef RESULT_SIGNED_EN
        chk("d3_neg", seg, 7'b0111111);
`else
        chk("d3_unsigned", seg, 7'h7F);
`endif
        wait_an(4'b1011);
`ifdef RESULT_SIGNED_EN
        chk("d2_neg1", seg, 7'h7F);
`else
        chk("d2_511", seg, 7'b0010010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
